// File: rtl/hc_pkg.sv
// Shared types and helpers for the round-robin Hamming encoder arbiter.
package hc_pkg;

    localparam int unsigned DATA_WD_DEF = 4;
    localparam int unsigned CHK_WD_DEF  = 3;
    localparam int unsigned MAX_REQ     = 32;
    localparam int unsigned MAX_REQ_W   = 5;

    typedef enum logic {EMPTY, FULL} arb_state_e;

    // First asserted valid at or after ptr, wrapping modulo num; one-hot or zero.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input int unsigned       ptr,
                                                   input int unsigned       num);
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int unsigned        idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (ptr + i) % num;
            if (i < num && !found && valid[idx[MAX_REQ_W-1:0]]) begin
                gnt[idx[MAX_REQ_W-1:0]] = 1'b1;
                found                   = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/hc_enc.sv
// Combinational Hamming encoder: codeword bit p-1 holds position p, parity at powers of two.
module hc_enc #(
    parameter int unsigned DATA_WD = 4,
    parameter int unsigned CHK_WD  = 3
) (
    input  logic [DATA_WD-1:0]        data_i,
    output logic [DATA_WD+CHK_WD-1:0] code_o
);

    localparam int unsigned CW = DATA_WD + CHK_WD;

    logic [DATA_WD-1:0] rem;
    logic [CW-1:0]      cw;
    logic [CW-1:0]      mask;

    always_comb begin
        rem  = data_i;
        cw   = '0;
        mask = '0;
        // Data fills the non-power-of-two positions in ascending order.
        for (int unsigned p = 1; p <= CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = rem[0];
                rem     = rem >> 1;
            end
        end
        for (int unsigned c = 0; c < CHK_WD; c++) begin
            mask = '0;
            for (int unsigned p = 1; p <= CW; p++) begin
                if (((p >> c) & 1) != 0) begin
                    mask[p-1] = 1'b1;
                end
            end
            cw[(1 << c) - 1] = ^(cw & mask);
        end
        code_o = cw;
    end

endmodule

// File: rtl/hc_enc_arb.sv
// Round-robin arbiter sharing one Hamming encoder, with a single-entry output buffer.
module hc_enc_arb
    import hc_pkg::*;
#(
    parameter int unsigned DATA_WD = DATA_WD_DEF,
    parameter int unsigned CHK_WD  = CHK_WD_DEF,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_WD   = $clog2(NUM_REQ)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_WD+CHK_WD-1:0]    o_enc_data,
    output logic [ID_WD-1:0]             o_src_id
);

    localparam int unsigned CW = DATA_WD + CHK_WD;

    arb_state_e         state_q;
    logic [ID_WD-1:0]   rr_ptr_q;
    logic [ID_WD-1:0]   src_id_q;
    logic [CW-1:0]      enc_q;

    logic               load;
    logic               xfer;
    logic [MAX_REQ-1:0] gnt_full;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_WD-1:0]   gnt_idx;
    logic [DATA_WD-1:0] sel_data;
    logic [CW-1:0]      enc_w;
    logic               unused_gnt;

    assign load       = (state_q == EMPTY) || i_ready;
    assign gnt_full   = rr_pick(MAX_REQ'(i_req_valid), 32'(rr_ptr_q), NUM_REQ);
    assign gnt        = gnt_full[NUM_REQ-1:0];
    assign unused_gnt = ^gnt_full[MAX_REQ-1:NUM_REQ];

    always_comb begin
        gnt_idx  = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                gnt_idx  = ID_WD'(k);
                sel_data = i_req_data[k*DATA_WD +: DATA_WD];
            end
        end
    end

    // Reset gating keeps any request in the reset cycle from being accepted.
    assign o_req_ready = (load && i_rst_n) ? gnt : '0;
    assign xfer        = |o_req_ready;

    hc_enc #(
        .DATA_WD(DATA_WD),
        .CHK_WD (CHK_WD)
    ) u_hc_enc (
        .data_i(sel_data),
        .code_o(enc_w)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            enc_q    <= '0;
            src_id_q <= '0;
        end else if (xfer) begin
            state_q  <= FULL;
            enc_q    <= enc_w;
            src_id_q <= gnt_idx;
            rr_ptr_q <= (gnt_idx == ID_WD'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WD'(1);
        end else if (i_ready) begin
            state_q <= EMPTY;
        end
    end

    assign o_valid    = (state_q == FULL);
    assign o_enc_data = enc_q;
    assign o_src_id   = src_id_q;

endmodule

// File: tb/tb_hc_enc_arb.sv
// Directed bench for hc_enc_arb with a queue scoreboard checked by a separate output monitor.
module tb_hc_enc_arb;

    logic        i_clk;
    logic        i_rst_n;
    logic [3:0]  i_req_valid;
    logic [15:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic        o_valid;
    logic        i_ready;
    logic [6:0]  o_enc_data;
    logic [1:0]  o_src_id;

    int n_cmp = 0;
    int n_mis = 0;
    logic [8:0] sb_q[$];

    hc_enc_arb #(
        .DATA_WD(4),
        .CHK_WD (3),
        .NUM_REQ(4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req_valid(i_req_valid),
        .i_req_data (i_req_data),
        .o_req_ready(o_req_ready),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_enc_data (o_enc_data),
        .o_src_id   (o_src_id)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every word leaving the buffer must match the oldest expected entry.
    always @(negedge i_clk) begin
        logic [8:0] exp_e;
        if (i_rst_n && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL sb_underflow: got word 0x%0h id %0d, expected none", o_enc_data,
                         o_src_id);
            end else begin
                exp_e = sb_q.pop_front();
                chk("enc_data", 32'(o_enc_data), 32'(exp_e[8:2]));
                chk("src_id", 32'(o_src_id), 32'(exp_e[1:0]));
            end
        end
    end

    task automatic set_data(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                            input logic [3:0] d3);
        i_req_data = {d3, d2, d1, d0};
    endtask

    // One cycle: check valid/ready mid-cycle, log the expected word if a grant is due.
    task automatic step(input logic exp_v, input logic [3:0] exp_rdy, input logic [6:0] code,
                        input logic [1:0] id);
        @(negedge i_clk);
        chk("o_valid", 32'(o_valid), 32'(exp_v));
        chk("o_req_ready", 32'(o_req_ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0000) sb_q.push_back({code, id});
        @(posedge i_clk);
        #1;
    endtask

    task automatic stall(input logic [6:0] code, input logic [1:0] id);
        @(negedge i_clk);
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_ready", 32'(o_req_ready), 32'd0);
        chk("stall_data", 32'(o_enc_data), 32'(code));
        chk("stall_id", 32'(o_src_id), 32'(id));
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = 4'b1111;
        i_ready     = 1'b1;
        set_data(4'h3, 4'h5, 4'h9, 4'h6);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        chk("rst_data", 32'(o_enc_data), 32'd0);
        chk("rst_id", 32'(o_src_id), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Rotation with all requesters valid: 3->1E, 5->2D, 9->4C, 6->33.
        step(1'b0, 4'b0001, 7'h1E, 2'd0);
        step(1'b1, 4'b0010, 7'h2D, 2'd1);
        step(1'b1, 4'b0100, 7'h4C, 2'd2);
        step(1'b1, 4'b1000, 7'h33, 2'd3);
        step(1'b1, 4'b0001, 7'h1E, 2'd0);

        // Backpressure holding req0's word; pointer must still sit at 1.
        i_ready = 1'b0;
        stall(7'h1E, 2'd0);
        stall(7'h1E, 2'd0);
        stall(7'h1E, 2'd0);
        i_ready = 1'b1;
        step(1'b1, 4'b0010, 7'h2D, 2'd1);
        i_req_valid = 4'b0000;
        step(1'b1, 4'b0000, 7'h00, 2'd0);
        step(1'b0, 4'b0000, 7'h00, 2'd0);

        // Single requester 1 with several data patterns, back to back.
        set_data(4'h3, 4'hB, 4'h9, 4'h6);
        i_req_valid = 4'b0010;
        step(1'b0, 4'b0010, 7'h55, 2'd1);
        i_req_valid = 4'b0000;
        step(1'b1, 4'b0000, 7'h00, 2'd0);
        set_data(4'h3, 4'h0, 4'h9, 4'h6);
        i_req_valid = 4'b0010;
        step(1'b0, 4'b0010, 7'h00, 2'd1);
        set_data(4'h3, 4'h1, 4'h9, 4'h6);
        step(1'b1, 4'b0010, 7'h07, 2'd1);
        set_data(4'h3, 4'hF, 4'h9, 4'h6);
        step(1'b1, 4'b0010, 7'h7F, 2'd1);
        i_req_valid = 4'b0000;
        step(1'b1, 4'b0000, 7'h00, 2'd0);
        step(1'b0, 4'b0000, 7'h00, 2'd0);

        // Pointer skip: grant req2 (ptr->3), then req1/req2 valid picks req1 (ptr->2).
        set_data(4'h3, 4'h2, 4'h9, 4'h6);
        i_req_valid = 4'b0100;
        step(1'b0, 4'b0100, 7'h4C, 2'd2);
        set_data(4'h3, 4'h2, 4'h4, 4'h6);
        i_req_valid = 4'b0110;
        step(1'b1, 4'b0010, 7'h19, 2'd1);
        step(1'b1, 4'b0100, 7'h2A, 2'd2);
        // Wrap: winner 3 sends the pointer to 0, so req0 beats req3 next.
        i_req_valid = 4'b1000;
        step(1'b1, 4'b1000, 7'h33, 2'd3);
        set_data(4'h3, 4'h2, 4'h4, 4'h6);
        i_req_valid = 4'b1001;
        step(1'b1, 4'b0001, 7'h1E, 2'd0);

        // Reset mid-stream while FULL and stalled; buffered word is discarded.
        i_req_valid = 4'b0000;
        i_ready     = 1'b0;
        stall(7'h1E, 2'd0);
        i_rst_n     = 1'b0;
        i_req_valid = 4'b1111;
        sb_q.delete();
        @(negedge i_clk);
        chk("rst_mid_ready", 32'(o_req_ready), 32'd0);
        @(negedge i_clk);
        chk("rst_mid_valid", 32'(o_valid), 32'd0);
        chk("rst_mid_data", 32'(o_enc_data), 32'd0);
        chk("rst_mid_id", 32'(o_src_id), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n     = 1'b1;
        i_ready     = 1'b1;
        set_data(4'h3, 4'h5, 4'h9, 4'h6);
        i_req_valid = 4'b0011;
        step(1'b0, 4'b0001, 7'h1E, 2'd0);
        step(1'b1, 4'b0010, 7'h2D, 2'd1);
        i_req_valid = 4'b0000;
        step(1'b1, 4'b0000, 7'h00, 2'd0);
        step(1'b0, 4'b0000, 7'h00, 2'd0);

        chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
